// File: rtl/kbd_evt_pkg.sv
// Shared types for the keycode event queue: event kinds, the event record,
// the "no key" keycode and the debounce/commit FSM state encoding.
package kbd_evt_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'b00,
    EVT_RELEASE = 2'b01,
    EVT_REPEAT  = 2'b10
  } evt_kind_t;

  typedef struct packed {
    evt_kind_t  kind;
    logic [7:0] code;
  } kbd_evt_t;

  localparam logic [7:0] KC_NONE = 8'h00;

  // Head value presented while the queue is empty.
  localparam kbd_evt_t EVT_NONE = '{kind: EVT_PRESS, code: KC_NONE};

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REL  = 2'b01,
    ST_PRS  = 2'b10
  } kq_state_t;

endpackage

// File: rtl/evt_fifo.sv
// Synchronous FIFO of keyboard events with a combinational head output.
// Ports: i_clk, i_rst_n (async low), i_push/i_din, i_pop, o_dout (head,
// EVT_NONE when empty), o_full, o_empty, o_count (occupancy).
// A push while full is accepted only if a pop happens in the same cycle;
// a pop on an empty FIFO is ignored. DEPTH must be a power of 2.
module evt_fifo
  import kbd_evt_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  kbd_evt_t      i_din,
  input  logic          i_pop,
  output kbd_evt_t      o_dout,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);

  kbd_evt_t        r_mem [DEPTH];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [CW-1:0]   r_cnt;

  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(DEPTH));
  assign w_pop   = i_pop & ~w_empty;
  // A simultaneous pop frees the slot the push needs.
  assign w_push  = i_push & (~w_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr] <= i_din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + AW'(1);
      end
      if (w_pop) begin
        r_rd <= r_rd + AW'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_dout  = w_empty ? EVT_NONE : r_mem[r_rd];
  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_count = r_cnt;

endmodule

// File: rtl/keycode_event_queue.sv
// Debounces the raw SoC keycode and turns committed level changes into
// ordered press/release (and optional repeat) events held in a small FIFO.
// Ports: clk_clk, reset_reset_n (async low), keycode_export (raw code),
// evt_valid/evt_ready/evt_code/evt_kind (head + pop handshake), evt_count,
// overflow (sticky drop flag), clr_overflow (sync clear; set wins).
// Optional: define KEY_REPEAT_EN to emit repeat events while a key is held.
module keycode_event_queue
  import kbd_evt_pkg::*;
#(
  parameter  int STABLE_CYCLES = 16,
  parameter  int FIFO_DEPTH    = 8,
  parameter  int REPEAT_DELAY  = 25000000,
  parameter  int REPEAT_PERIOD = 5000000,
  localparam int CW            = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic [7:0]    keycode_export,
  output logic          evt_valid,
  input  logic          evt_ready,
  output logic [7:0]    evt_code,
  output logic [1:0]    evt_kind,
  output logic [CW-1:0] evt_count,
  output logic          overflow,
  input  logic          clr_overflow
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (STABLE_CYCLES < 1) begin : g_bad_stab
    $error("STABLE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_rep
    $error("REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [7:0]    r_cand;
  logic [SW-1:0] r_stab_cnt;
  logic [7:0]    r_committed;
  logic [7:0]    r_target;
  kq_state_t     r_state;
  logic          r_ovf;

  logic          w_stable;
  logic          w_start;
  logic          w_push;
  kbd_evt_t      w_din;
  logic          w_pop;
  kbd_evt_t      w_head;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic          w_drop;
  logic          w_rep_fire;

  assign w_stable = (r_stab_cnt == STAB_MAX);
  assign w_start  = (r_state == ST_IDLE) & w_stable &
                    (r_cand != r_committed);

  // Candidate tracking is independent of the FSM so that a change seen
  // while REL/PRS are busy is still counted and picked up back in IDLE.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_cand     <= KC_NONE;
      r_stab_cnt <= '0;
    end else if (keycode_export != r_cand) begin
      r_cand     <= keycode_export;
      r_stab_cnt <= '0;
    end else if (!w_stable) begin
      r_stab_cnt <= r_stab_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state     <= ST_IDLE;
      r_committed <= KC_NONE;
      r_target    <= KC_NONE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_target <= r_cand;
            r_state  <= (r_committed != KC_NONE) ? ST_REL : ST_PRS;
          end
        end
        ST_REL: begin
          r_committed <= KC_NONE;
          r_state     <= (r_target != KC_NONE) ? ST_PRS : ST_IDLE;
        end
        ST_PRS: begin
          r_committed <= r_target;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                           REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HW      = $clog2(REP_MAX + 1);

  logic [HW-1:0] r_hold;
  logic          r_rep_armed;
  logic          w_hold_cond;
  logic [HW-1:0] w_hold_lim;

  // Holding: idle with a key committed and the raw code still matching it.
  assign w_hold_cond = (r_state == ST_IDLE) &
                       (r_committed != KC_NONE) &
                       (r_cand == r_committed);
  // First repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
  assign w_hold_lim  = r_rep_armed ? HW'(REPEAT_PERIOD - 1) :
                                     HW'(REPEAT_DELAY - 1);
  assign w_rep_fire  = w_hold_cond & (r_hold == w_hold_lim);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_hold      <= '0;
      r_rep_armed <= 1'b0;
    end else if (r_state == ST_REL || r_state == ST_PRS) begin
      r_hold      <= '0;
      r_rep_armed <= 1'b0;
    end else if (w_rep_fire) begin
      r_hold      <= '0;
      r_rep_armed <= 1'b1;
    end else if (w_hold_cond) begin
      r_hold <= r_hold + HW'(1);
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

  always_comb begin
    w_push = 1'b0;
    w_din  = EVT_NONE;
    unique case (r_state)
      ST_REL: begin
        w_push = 1'b1;
        w_din  = '{kind: EVT_RELEASE, code: r_committed};
      end
      ST_PRS: begin
        w_push = 1'b1;
        w_din  = '{kind: EVT_PRESS, code: r_target};
      end
      ST_IDLE: begin
        if (w_rep_fire) begin
          w_push = 1'b1;
          w_din  = '{kind: EVT_REPEAT, code: r_committed};
        end
      end
      default: begin
        w_push = 1'b0;
      end
    endcase
  end

  assign w_pop  = evt_ready & ~w_empty;
  assign w_drop = w_push & w_full & ~w_pop;

  evt_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_clk),
    .i_rst_n (reset_reset_n),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clr_overflow) begin
      r_ovf <= 1'b0;
    end
  end

  assign evt_valid = ~w_empty;
  assign evt_code  = w_head.code;
  assign evt_kind  = w_head.kind;
  assign evt_count = w_count;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_keycode_event_queue.sv
// Directed bench for keycode_event_queue with small parameters.
// Repeat checks run only when KEY_REPEAT_EN is defined.
module tb_keycode_event_queue;

  localparam int S  = 4;
  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    kc = 8'h00;
  logic          rdy = 1'b0;
  logic          clr = 1'b0;
  logic          vld;
  logic [7:0]    code;
  logic [1:0]    kind;
  logic [CW-1:0] cnt;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keycode_event_queue #(
    .STABLE_CYCLES (S),
    .FIFO_DEPTH    (D),
    .REPEAT_DELAY  (RD),
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .keycode_export (kc),
    .evt_valid      (vld),
    .evt_ready      (rdy),
    .evt_code       (code),
    .evt_kind       (kind),
    .evt_count      (cnt),
    .overflow       (ovf),
    .clr_overflow   (clr)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_vld"},  32'(vld),  32'h0);
    chk({tag, "_code"}, 32'(code), 32'h0);
    chk({tag, "_kind"}, 32'(kind), 32'h0);
    chk({tag, "_cnt"},  32'(cnt),  32'h0);
    chk({tag, "_ovf"},  32'(ovf),  32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    int   press_t;
    int   nrep;
    int   rep_t [3];

    // Reset state.
    tick(2);
    chk_zero("rst");
    rst_n = 1'b1;
    tick(2);

    // Single press, popped immediately.
    rdy = 1'b1;
    kc  = 8'h04;
    tick(5);
    chk("t1_early_vld", 32'(vld), 32'h0);
    tick(1);
    chk("t1_vld",  32'(vld),  32'h1);
    chk("t1_code", 32'(code), 32'h04);
    chk("t1_kind", 32'(kind), 32'h0);
    chk("t1_cnt",  32'(cnt),  32'h1);
    tick(1);
    chk("t1_pop_vld", 32'(vld), 32'h0);
    tick(3);
    chk("t1_hold_cnt", 32'(cnt), 32'h0);

    // Direct change: release then press on consecutive cycles.
    kc = 8'h1A;
    tick(6);
    chk("t2_rel_kind", 32'(kind), 32'h1);
    chk("t2_rel_code", 32'(code), 32'h04);
    tick(1);
    chk("t2_prs_kind", 32'(kind), 32'h0);
    chk("t2_prs_code", 32'(code), 32'h1A);
    chk("t2_prs_cnt",  32'(cnt),  32'h1);
    tick(1);
    chk("t2_drain", 32'(cnt), 32'h0);

    // Release to no-key, then a short glitch that must be ignored.
    kc = 8'h00;
    tick(8);
    chk("t3_rel_drain", 32'(cnt), 32'h0);
    kc = 8'h07;
    tick(2);
    kc = 8'h00;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (vld) seen = 1'b1;
    end
    chk("t3_glitch_seen", 32'(seen), 32'h0);
    chk("t3_glitch_cnt",  32'(cnt),  32'h0);

    // Fill with consumer stalled, force a drop.
    rdy = 1'b0;
    kc  = 8'h05;
    tick(8);
    chk("t4_cnt1", 32'(cnt), 32'h1);
    kc = 8'h06;
    tick(8);
    chk("t4_cnt3", 32'(cnt), 32'h3);
    kc = 8'h08;
    tick(8);
    chk("t4_full_cnt",  32'(cnt),  32'h4);
    chk("t4_ovf",       32'(ovf),  32'h1);
    chk("t4_head_kind", 32'(kind), 32'h0);
    chk("t4_head_code", 32'(code), 32'h05);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    chk("t4_clr_ovf", 32'(ovf), 32'h0);
    chk("t4_clr_cnt", 32'(cnt), 32'h4);

    // Push and pop together while full.
    kc = 8'h09;
    tick(5);
    rdy = 1'b1;
    tick(1);
    rdy = 1'b0;
    chk("t5_pp_cnt",  32'(cnt),  32'h4);
    chk("t5_pp_ovf",  32'(ovf),  32'h0);
    chk("t5_pp_kind", 32'(kind), 32'h1);
    chk("t5_pp_code", 32'(code), 32'h05);
    tick(1);
    chk("t5_drop_ovf", 32'(ovf), 32'h1);
    chk("t5_drop_cnt", 32'(cnt), 32'h4);

    // Reset in the middle of REL.
    kc = 8'h04;
    tick(5);
    rst_n = 1'b0;
    #1;
    chk_zero("t6_async");
    tick(2);
    rst_n = 1'b1;
    tick(5);
    chk("t6_early_vld", 32'(vld), 32'h0);
    tick(1);
    chk("t6_vld",  32'(vld),  32'h1);
    chk("t6_code", 32'(code), 32'h04);
    chk("t6_kind", 32'(kind), 32'h0);
    chk("t6_cnt",  32'(cnt),  32'h1);

`ifdef KEY_REPEAT_EN
    // Auto-repeat while held.
    rdy = 1'b1;
    tick(1);
    chk("t7_drain", 32'(cnt), 32'h0);
    kc      = 8'h16;
    press_t = -1;
    nrep    = 0;
    for (int i = 1; i <= 44; i++) begin
      tick(1);
      if (vld && kind == 2'b00 && code == 8'h16) press_t = i;
      if (vld && kind == 2'b10) begin
        if (nrep < 3) rep_t[nrep] = i;
        nrep++;
      end
    end
    chk("t7_press_t", 32'(press_t), 32'd7);
    chk("t7_nrep",    32'(nrep),    32'd3);
    chk("t7_rep0_t",  32'(rep_t[0]), 32'd27);
    chk("t7_rep1_t",  32'(rep_t[1]), 32'd35);
    chk("t7_rep2_t",  32'(rep_t[2]), 32'd43);
`else
    press_t  = 0;
    nrep     = 0;
    rep_t[0] = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
